// File: rtl/fcf_pkg.sv
// Shared encodings for the fast-cluster scheduler: serializer modes, FSM states, defaults.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package fcf_pkg;

  // Serializer control / mode request encodings
  localparam logic [1:0] FCF_OFF  = 2'b00;
  localparam logic [1:0] FCF_PATM = 2'b01;
  localparam logic [1:0] FCF_PATL = 2'b10;
  localparam logic [1:0] FCF_CLUS = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_PATTERN = 2'b01,
    ST_CLUSTER = 2'b10,
    ST_DRAIN   = 2'b11
  } fcf_state_e;

  localparam int          FCF_FIFO_DEPTH = 4;
  localparam int          FCF_HOLDOFF    = 2;
  localparam logic [15:0] FCF_PATTERN    = 16'h00FF;

  // One buffered BC: lane-valid flags plus the 32-bit hit (invalid halves zeroed)
  typedef struct packed {
    logic [1:0]  vld;
    logic [31:0] hit;
  } fcf_word_t;

  function automatic fcf_state_e mode_to_state(input logic [1:0] mode);
    case (mode)
      FCF_OFF:  return ST_IDLE;
      FCF_CLUS: return ST_CLUSTER;
      default:  return ST_PATTERN;
    endcase
  endfunction

endpackage

// File: rtl/fcf_sync_fifo.sv
// Single-clock FIFO for cluster words; full/empty/level flags.
// Latency: written word visible at dout_o the cycle after the push edge.
// Backpressure: push ignored when full unless a pop happens on the same edge; pop ignored when empty.
// Ports: clk_i, rst_ni (async active-low), push_i/din_i, pop_i/dout_o, full_o, empty_o, level_o.
module fcf_sync_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         din_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [AW:0]      cnt_q, cnt_d;
  logic             push_ok, pop_ok;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign level_o = cnt_q;
  assign dout_o  = mem_q[rd_q];

  assign pop_ok  = pop_i && !empty_o;
  // A pop on the same edge frees the slot, so a full FIFO still accepts the push
  assign push_ok = push_i && (!full_o || pop_ok);

  always_comb begin
    cnt_d = cnt_q;
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_q] <= din_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_ok) wr_q <= wr_q + AW'(1);
      if (pop_ok)  rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fast_cluster_sched.sv
// Buffers per-BC cluster words and sequences the two fast-readout serializers (off/pattern/cluster).
// Latency: hit sampled at edge k into an empty FIFO with idle lanes -> ser_load high after edge k+1.
// Backpressure: loads wait for lane idle (ser_busy low and holdoff expired); full FIFO drops and counts.
// Ports: BCclk, reset (async active-low); mode_req/mode_apply; hit_loc/hit_vld; ser_busy;
//        control, dff_reset, ser_load, ser_data_M/L, fifo_level, drop_count, state.
module fast_cluster_sched
  import fcf_pkg::*;
#(
  parameter int          FIFO_DEPTH = FCF_FIFO_DEPTH,
  parameter int          HOLDOFF    = FCF_HOLDOFF,
  parameter logic [15:0] PATTERN    = FCF_PATTERN
) (
  input  logic                        BCclk,
  input  logic                        reset,
  input  logic [1:0]                  mode_req,
  input  logic                        mode_apply,
  input  logic [31:0]                 hit_loc,
  input  logic [1:0]                  hit_vld,
  input  logic [1:0]                  ser_busy,
  output logic [1:0]                  control,
  output logic                        dff_reset,
  output logic [1:0]                  ser_load,
  output logic [15:0]                 ser_data_M,
  output logic [15:0]                 ser_data_L,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic [15:0]                 drop_count,
  output logic [1:0]                  state
);

  localparam int HW = $clog2(HOLDOFF + 1);

  fcf_state_e         state_q, state_d;
  logic [1:0]         control_q, control_d;
  logic [1:0]         target_q, target_d;
  logic [1:0]         pend;
  logic [1:0][HW-1:0] hold_q, hold_d;
  logic [1:0]         load_q, load_d;
  logic [15:0]        data_m_q, data_m_d, data_l_q, data_l_d;
  logic [15:0]        drop_q, drop_d;
  logic [1:0]         lane_idle;

  fcf_word_t          push_word, head_word;
  logic               push, pop, drop, fifo_full, fifo_empty;

  always_comb begin
    for (int n = 0; n < 2; n++) lane_idle[n] = !ser_busy[n] && (hold_q[n] == '0);
  end

  assign push_word.vld = hit_vld;
  assign push_word.hit = {hit_vld[1] ? hit_loc[31:16] : 16'h0, hit_vld[0] ? hit_loc[15:0] : 16'h0};

  // DRAIN keeps popping but never pushes, so the FIFO empties before the mode switch
  assign push = (state_q == ST_CLUSTER) && (hit_vld != 2'b00);
  assign pop  = ((state_q == ST_CLUSTER) || (state_q == ST_DRAIN)) && !fifo_empty &&
                ((head_word.vld & ~lane_idle) == 2'b00);
  assign drop = push && fifo_full && !pop;

  fcf_sync_fifo #(
    .WIDTH ($bits(fcf_word_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (BCclk),
    .rst_ni  (reset),
    .push_i  (push),
    .din_i   (push_word),
    .pop_i   (pop),
    .dout_o  (head_word),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  always_comb begin
    state_d   = state_q;
    control_d = control_q;
    target_d  = target_q;
    pend      = target_q;
    load_d    = 2'b00;
    data_m_d  = data_m_q;
    data_l_d  = data_l_q;
    drop_d    = drop_q;
    for (int n = 0; n < 2; n++) hold_d[n] = (hold_q[n] != '0) ? hold_q[n] - HW'(1) : hold_q[n];

    case (state_q)
      ST_IDLE, ST_PATTERN: begin
        if (mode_apply) begin
          state_d   = mode_to_state(mode_req);
          control_d = mode_req;
        end
      end
      ST_CLUSTER: begin
        if (mode_apply && (mode_req != FCF_CLUS)) begin
          state_d  = ST_DRAIN;
          target_d = mode_req;
        end
      end
      ST_DRAIN: begin
        // Latest request wins, including one arriving on the switch edge itself
        pend     = mode_apply ? mode_req : target_q;
        target_d = pend;
        if (fifo_empty && (&lane_idle)) begin
          state_d   = mode_to_state(pend);
          control_d = pend;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (pop) begin
      load_d   = head_word.vld;
      data_m_d = head_word.hit[31:16];
      data_l_d = head_word.hit[15:0];
    end else if ((state_q == ST_PATTERN) && (state_d == ST_PATTERN)) begin
      if ((control_d == FCF_PATM) && lane_idle[1]) load_d[1] = 1'b1;
      if ((control_d == FCF_PATL) && lane_idle[0]) load_d[0] = 1'b1;
    end

    // Outside cluster/drain the data words are fixed by the mode
    if (state_d == ST_IDLE) begin
      data_m_d = '0;
      data_l_d = '0;
    end else if (state_d == ST_PATTERN) begin
      data_m_d = (control_d == FCF_PATM) ? PATTERN : '0;
      data_l_d = (control_d == FCF_PATL) ? PATTERN : '0;
    end

    for (int n = 0; n < 2; n++) if (load_d[n]) hold_d[n] = HW'(HOLDOFF);

    if (drop && (drop_q != 16'hFFFF)) drop_d = drop_q + 16'd1;
  end

  always_ff @(posedge BCclk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      control_q <= FCF_OFF;
      target_q  <= FCF_OFF;
      hold_q    <= '0;
      load_q    <= 2'b00;
      data_m_q  <= '0;
      data_l_q  <= '0;
      drop_q    <= '0;
    end else begin
      state_q   <= state_d;
      control_q <= control_d;
      target_q  <= target_d;
      hold_q    <= hold_d;
      load_q    <= load_d;
      data_m_q  <= data_m_d;
      data_l_q  <= data_l_d;
      drop_q    <= drop_d;
    end
  end

  assign control    = control_q;
  assign dff_reset  = (state_q != ST_CLUSTER);
  assign ser_load   = load_q;
  assign ser_data_M = data_m_q;
  assign ser_data_L = data_l_q;
  assign drop_count = drop_q;
  assign state      = state_q;

endmodule
